// File: rtl/stack_sequencer.sv
// stack_sequencer: sequences register PUSH/POP through $sp into data memory, tracking stack depth.
module stack_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_req,
    input  logic       pop_req,
    input  logic [1:0] push_src_addr,
    input  logic [1:0] pop_dst_addr,
    input  logic [7:0] rf_rd_data,
    input  logic [7:0] sp_data,
    input  logic [7:0] mem_rdata,
    output logic [1:0] rf_rd_addr,
    output logic       rf_wr_en,
    output logic [1:0] rf_wr_addr,
    output logic [7:0] rf_wr_data,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] depth
);
    localparam logic [3:0] IDLE = 4'd0, ERR = 4'd1, P_RD = 4'd2, P_WR = 4'd3, P_SP = 4'd4;
    localparam logic [3:0] Q_RD = 4'd5, Q_MEM = 4'd6, Q_WAIT = 4'd7, Q_WR = 4'd8, Q_SP = 4'd9;
    localparam logic [7:0] FULL = 8'(DEPTH);
    localparam logic [1:0] SP = 2'b10;

    logic [3:0] state_q, state_d;
    logic [7:0] sp_q, sp_d, depth_q, depth_d;
    logic [1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d, maddr_q, maddr_d, mwdata_q, mwdata_d;
    logic       wr_en_q, wr_en_d, we_q, we_d, re_q, re_d, done_q, done_d, err_q, err_d;

    // Outputs are registered on entry to each state, so address/data hold between strobes.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        depth_d   = depth_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        wr_en_d   = 1'b0;
        we_d      = 1'b0;
        re_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (push_req) begin
                    if (depth_q == FULL) begin
                        state_d = ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = P_RD;
                        rd_addr_d = push_src_addr;
                    end
                end else if (pop_req) begin
                    state_d = (depth_q == 8'd0) ? ERR : Q_RD;
                    done_d  = (depth_q == 8'd0);
                    err_d   = (depth_q == 8'd0);
                end
            end
            ERR: state_d = IDLE;
            P_RD: begin
                state_d  = P_WR;
                sp_d     = sp_data;
                we_d     = 1'b1;
                maddr_d  = sp_data;
                mwdata_d = rf_rd_data;
            end
            P_WR: begin
                state_d   = P_SP;
                wr_en_d   = 1'b1;
                wr_addr_d = SP;
                wr_data_d = sp_q - 8'd1;
                done_d    = 1'b1;
            end
            P_SP: begin
                state_d = IDLE;
                depth_d = depth_q + 8'd1;
            end
            Q_RD: begin
                state_d = Q_MEM;
                sp_d    = sp_data;
                re_d    = 1'b1;
                maddr_d = sp_data + 8'd1;
            end
            Q_MEM: state_d = Q_WAIT;
            Q_WAIT: begin
                state_d   = Q_WR;
                wr_en_d   = 1'b1;
                wr_addr_d = pop_dst_addr;
                wr_data_d = mem_rdata;
                done_d    = (pop_dst_addr == SP);
            end
            Q_WR: begin
                // Popping into $sp makes the popped byte the new $sp, so no separate $sp write.
                if (wr_addr_q == SP) begin
                    state_d = IDLE;
                    depth_d = depth_q - 8'd1;
                end else begin
                    state_d   = Q_SP;
                    wr_en_d   = 1'b1;
                    wr_addr_d = SP;
                    wr_data_d = sp_q + 8'd1;
                    done_d    = 1'b1;
                end
            end
            Q_SP: begin
                state_d = IDLE;
                depth_d = depth_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sp_q      <= '0;
            depth_q   <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            wr_en_q   <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            depth_q   <= depth_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            wr_en_q   <= wr_en_d;
            we_q      <= we_d;
            re_q      <= re_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rf_rd_addr = rd_addr_q;
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;
    assign mem_we     = we_q;
    assign mem_re     = re_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign depth      = depth_q;
endmodule
